board_eval: RTL and testbench

Avalon-MM accelerator that consumes the candidate boards written to SDRAM by the piece move generators. The CPU programs a base address and a board count through the slave port. For each 64-word board, the block reads every square through the master port, computes a signed material score and writes that score to a result array in SDRAM. It then reports the index and score of the best board for the side to move.

---
 rtl/chess_pkg.sv | 41 ++++
 rtl/piece_weight.sv | 34 +++
 rtl/board_eval.sv | 183 ++++++++++++++++++
 tb/tb_board_eval.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// chess_pkg: piece encoding, material weights and the evaluator state type.
// Shared by the board evaluator and the piece move generators.
package chess_pkg;

   localparam int BOARD_WORDS = 64;
   localparam int BOARD_BYTES = 256;

   // Piece magnitudes; the sign of the 8-bit piece gives the colour.
   localparam logic [7:0] PC_PAWN   = 8'd1;
   localparam logic [7:0] PC_KNIGHT = 8'd2;
   localparam logic [7:0] PC_BISHOP = 8'd3;
   localparam logic [7:0] PC_ROOK   = 8'd4;
   localparam logic [7:0] PC_QUEEN  = 8'd5;
   localparam logic [7:0] PC_KING   = 8'd6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_NEXT,
      ST_RD,
      ST_WT,
      ST_INC,
      ST_WR,
      ST_DONE
   } eval_state_t;

   // Material weight of a piece magnitude; unknown magnitudes weigh nothing.
   function automatic logic [15:0] material_weight(input logic [7:0]  mag,
                                                   input logic [15:0] king_w);
      logic [15:0] w;
      case (mag)
         PC_PAWN:              w = 16'd1;
         PC_KNIGHT, PC_BISHOP: w = 16'd3;
         PC_ROOK:              w = 16'd5;
         PC_QUEEN:             w = 16'd9;
         PC_KING:              w = king_w;
         default:              w = 16'd0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/piece_weight.sv
// piece_weight: signed score contribution of one square.
// With BOARD_EVAL_CENTER_EN defined, any nonzero piece on d4/e4/d5/e5 adds
// its sign (+1 white, -1 black) on top of the material weight.
module piece_weight
   import chess_pkg::*;
#(
   parameter int KING_WEIGHT = 200
) (
   input  logic signed [7:0]  i_piece,
`ifdef BOARD_EVAL_CENTER_EN
   input  logic        [5:0]  i_square,
`endif
   output logic signed [15:0] o_contrib
);

   logic        [7:0]  w_mag;
   logic signed [15:0] w_weight;

   // -128 maps to magnitude 128, which weighs 0.
   assign w_mag    = i_piece[7] ? 8'(-i_piece) : 8'(i_piece);
   assign w_weight = signed'(material_weight(w_mag, 16'(KING_WEIGHT)));

   // Apply the piece colour to the weight, then the optional centre bonus.
   always_comb begin
      o_contrib = i_piece[7] ? -w_weight : w_weight;
`ifdef BOARD_EVAL_CENTER_EN
      if ((i_piece != 8'sd0) &&
          ((i_square[2:0] == 3'd3) || (i_square[2:0] == 3'd4)) &&
          ((i_square[5:3] == 3'd3) || (i_square[5:3] == 3'd4)))
         o_contrib = o_contrib + (i_piece[7] ? -16'sd1 : 16'sd1);
`endif
   end

endmodule

// File: rtl/board_eval.sv
// board_eval: Avalon-MM board material evaluator.
// Reads each 64-square board from SDRAM, writes its signed score to the
// result array and tracks the best board for the side to move.
// Optional macro: BOARD_EVAL_CENTER_EN (centre-square bonus in piece_weight).
//
// state | meaning
// IDLE  | accept register writes / start, serve best-result reads
// NEXT  | all boards done -> DONE, else clear accumulator for board b
// RD    | issue square read, hold until accepted
// WT    | wait for read data, accumulate contribution
// INC   | advance square or finish board
// WR    | write board score, update best on acceptance
// DONE  | results ready; read of 0/1 or any write returns to IDLE
module board_eval
   import chess_pkg::*;
#(
   parameter int MAX_BOARDS  = 32,
   parameter int KING_WEIGHT = 200
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        slave_waitrequest,
   input  logic [3:0]  slave_address,
   input  logic        slave_read,
   output logic [31:0] slave_readdata,
   input  logic        slave_write,
   input  logic [31:0] slave_writedata,
   input  logic        master_waitrequest,
   output logic [31:0] master_address,
   output logic        master_read,
   input  logic [31:0] master_readdata,
   input  logic        master_readdatavalid,
   output logic        master_write,
   output logic [31:0] master_writedata
);

   localparam int         BW      = $clog2(MAX_BOARDS + 1);
   localparam logic [5:0] LAST_SQ = 6'(BOARD_WORDS - 1);

   eval_state_t        r_state;
   logic [31:0]        r_board_base;
   logic [31:0]        r_result_base;
   logic [BW-1:0]      r_count;
   logic               r_side;
   logic [BW-1:0]      r_b;
   logic [5:0]         r_sq;
   logic signed [15:0] r_acc;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
   logic [31:0]        r_best_index;
   logic [31:0]        r_best_score;

   logic signed [7:0]  w_piece;
   logic signed [15:0] w_contrib;
   logic               w_better;
   logic               w_idle_or_done;
   logic               w_unused_rdata;

   assign w_piece        = signed'(master_readdata[7:0]);
   assign w_unused_rdata = ^master_readdata[31:8];

   piece_weight #(
      .KING_WEIGHT(KING_WEIGHT)
   ) u_piece_weight (
      .i_piece  (w_piece),
`ifdef BOARD_EVAL_CENTER_EN
      .i_square (r_sq),
`endif
      .o_contrib(w_contrib)
   );

   // First board always wins so the sentinel never survives a nonzero count.
   assign w_better = (r_b == '0) ||
                     (r_side ? ($signed(r_wdata) < $signed(r_best_score))
                             : ($signed(r_wdata) > $signed(r_best_score)));

   assign w_idle_or_done   = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign slave_waitrequest = (slave_read || slave_write) && !w_idle_or_done;
   assign master_read       = (r_state == ST_RD);
   assign master_write      = (r_state == ST_WR);
   assign master_address    = r_addr;
   assign master_writedata  = r_wdata;

   // Register read mux; only meaningful while idle or done.
   always_comb begin
      slave_readdata = 32'd0;
      if (w_idle_or_done) begin
         case (slave_address)
            4'd0:    slave_readdata = r_best_index;
            4'd1:    slave_readdata = r_best_score;
            default: slave_readdata = 32'd0;
         endcase
      end
   end

   // Control FSM with configuration, scan and best-board registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_board_base  <= 32'd0;
         r_result_base <= 32'd0;
         r_count       <= '0;
         r_side        <= 1'b0;
         r_b           <= '0;
         r_sq          <= 6'd0;
         r_acc         <= 16'sd0;
         r_addr        <= 32'hFFFF_FFFF;
         r_wdata       <= 32'd0;
         r_best_index  <= 32'd0;
         r_best_score  <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (slave_write) begin
                  case (slave_address)
                     4'd0: begin
                        r_b          <= '0;
                        r_best_index <= 32'hFFFF_FFFF;
                        r_best_score <= 32'h8000_0000;
                        r_state      <= ST_NEXT;
                     end
                     4'd1: r_board_base <= slave_writedata;
                     4'd2: r_count <= (slave_writedata > 32'(MAX_BOARDS)) ?
                                      BW'(MAX_BOARDS) : slave_writedata[BW-1:0];
                     4'd3: r_result_base <= slave_writedata;
                     4'd4: r_side <= slave_writedata[0];
                     default: ;
                  endcase
               end
            end
            ST_NEXT: begin
               if (r_b == r_count) begin
                  r_state <= ST_DONE;
               end else begin
                  r_acc   <= 16'sd0;
                  r_sq    <= 6'd0;
                  r_addr  <= r_board_base + 32'(r_b) * 32'(BOARD_BYTES);
                  r_state <= ST_RD;
               end
            end
            ST_RD: begin
               if (!master_waitrequest)
                  r_state <= ST_WT;
            end
            ST_WT: begin
               if (master_readdatavalid) begin
                  r_acc   <= r_acc + w_contrib;
                  r_state <= ST_INC;
               end
            end
            ST_INC: begin
               if (r_sq == LAST_SQ) begin
                  r_addr  <= r_result_base + (32'(r_b) << 2);
                  r_wdata <= {{16{r_acc[15]}}, r_acc};
                  r_state <= ST_WR;
               end else begin
                  r_sq    <= r_sq + 6'd1;
                  r_addr  <= r_addr + 32'd4;
                  r_state <= ST_RD;
               end
            end
            ST_WR: begin
               if (!master_waitrequest) begin
                  if (w_better) begin
                     r_best_index <= 32'(r_b);
                     r_best_score <= r_wdata;
                  end
                  r_b     <= r_b + 1'b1;
                  r_state <= ST_NEXT;
               end
            end
            ST_DONE: begin
               if (slave_write)
                  r_state <= ST_IDLE;
               else if (slave_read && (slave_address <= 4'd1))
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_board_eval.sv
// tb_board_eval: randomized scoreboard bench for board_eval with an SDRAM
// model (optional random stalls and read latency) and a material model.
module tb_board_eval;

   localparam int KW    = 200;
   localparam int MAXB  = 32;
   localparam int LIMIT = 40000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        slave_waitrequest;
   logic [3:0]  slave_address = 4'd0;
   logic        slave_read = 1'b0;
   logic [31:0] slave_readdata;
   logic        slave_write = 1'b0;
   logic [31:0] slave_writedata = 32'd0;
   logic        master_waitrequest = 1'b0;
   logic [31:0] master_address;
   logic        master_read;
   logic [31:0] master_readdata = 32'd0;
   logic        master_readdatavalid = 1'b0;
   logic        master_write;
   logic [31:0] master_writedata;

   board_eval #(.MAX_BOARDS(MAXB), .KING_WEIGHT(KW)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .slave_waitrequest   (slave_waitrequest),
      .slave_address       (slave_address),
      .slave_read          (slave_read),
      .slave_readdata      (slave_readdata),
      .slave_write         (slave_write),
      .slave_writedata     (slave_writedata),
      .master_waitrequest  (master_waitrequest),
      .master_address      (master_address),
      .master_read         (master_read),
      .master_readdata     (master_readdata),
      .master_readdatavalid(master_readdatavalid),
      .master_write        (master_write),
      .master_writedata    (master_writedata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          t_start = 0;
   int          last_wr_time = 0;
   int          req_cycles = 0;
   bit          rand_mode = 1'b0;
   wr_t         exp_q[$];
   wr_t         obs_q[$];
   logic [31:0] mem [logic [31:0]];
   logic signed [7:0] bd [0:MAXB-1][0:63];
   int          wtab [0:6] = '{0, 1, 3, 3, 5, 9, KW};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // SDRAM model: decisions made on the falling edge apply to the next rising edge.
   bit          pend = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_addr, prev_data;
   logic        prev_rd, prev_wr;
   always @(negedge clk) begin
      bit          wr_n;
      logic [31:0] r;
      r = $urandom;
      master_readdatavalid = 1'b0;
      master_readdata = r;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            master_readdatavalid = 1'b1;
            master_readdata = mem.exists(pend_addr) ? mem[pend_addr] : 32'hDEAD_0000;
            pend = 1'b0;
         end
      end
      if (prev_stall) begin
         checks++;
         if (master_address !== prev_addr || master_read !== prev_rd ||
             master_write !== prev_wr || (prev_wr && master_writedata !== prev_data)) begin
            failures++;
            $display("FAIL stall_stable addr=%h required=%h rd=%b wr=%b", master_address,
                     prev_addr, master_read, master_write);
         end
      end
      if (master_read || master_write) begin
         req_cycles++;
         checks++;
         if (master_read && master_write) begin
            failures++;
            $display("FAIL rd_wr_exclusive actual=both required=one");
         end
      end
      wr_n = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
      master_waitrequest = wr_n;
      prev_stall = (master_read || master_write) && wr_n;
      prev_addr  = master_address;
      prev_data  = master_writedata;
      prev_rd    = master_read;
      prev_wr    = master_write;
      if (master_read && !wr_n) begin
         pend      = 1'b1;
         pend_cnt  = rand_mode ? $urandom_range(1, 5) : 1;
         pend_addr = master_address;
      end
      if (master_write && !wr_n) begin
         obs_q.push_back('{master_address, master_writedata});
         last_wr_time = cyc + 1;
      end
   end

   // Monitor: every accepted SDRAM write is matched against the expected queue.
   initial forever begin
      wr_t o, e;
      @(posedge clk);
      #2;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%h data=%h required=none", o.addr, o.data);
         end else begin
            e = exp_q.pop_front();
            if (o.addr !== e.addr || o.data !== e.data) begin
               failures++;
               $display("FAIL score_write addr=%h data=%h required addr=%h data=%h",
                        o.addr, o.data, e.addr, e.data);
            end
         end
      end
   end

   task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
      int n;
      @(negedge clk);
      slave_address = a;
      slave_writedata = d;
      slave_write = 1'b1;
      n = 0;
      #1;
      while (slave_waitrequest && n < LIMIT) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= LIMIT) begin
         failures++;
         $display("FAIL cpu_write_timeout addr=%0d", a);
      end
      @(posedge clk);
      #1;
      t_start = cyc;
      slave_write = 1'b0;
   endtask

   task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int waits);
      int n;
      @(negedge clk);
      slave_address = a;
      slave_read = 1'b1;
      n = 0;
      #1;
      while (slave_waitrequest && n < LIMIT) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= LIMIT) begin
         failures++;
         $display("FAIL cpu_read_timeout addr=%0d waited=%0d", a, n);
      end
      d = slave_readdata;
      waits = n;
      @(posedge clk);
      #1;
      slave_read = 1'b0;
   endtask

   // Reference: sum of signed weights, plus centre bonus when enabled.
   function automatic int ref_score(input int b);
      int s, pc, m, x, y;
      s = 0;
      for (int sq = 0; sq < 64; sq++) begin
         pc = bd[b][sq];
         m  = (pc < 0) ? -pc : pc;
         if (m <= 6) s += (pc < 0) ? -wtab[m] : wtab[m];
`ifdef BOARD_EVAL_CENTER_EN
         x = sq % 8;
         y = sq / 8;
         if (pc != 0 && (x == 3 || x == 4) && (y == 3 || y == 4)) s += (pc < 0) ? -1 : 1;
`else
         x = 0;
         y = 0;
`endif
      end
      return s;
   endfunction

   task automatic clear_boards();
      for (int b = 0; b < MAXB; b++)
         for (int sq = 0; sq < 64; sq++) bd[b][sq] = 8'sd0;
   endtask

   task automatic gen_boards(input int n);
      int r;
      for (int b = 0; b < n; b++)
         for (int sq = 0; sq < 64; sq++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      bd[b][sq] = 8'sd0;
            else if (r < 9) bd[b][sq] = 8'($urandom_range(0, 12) - 6);
            else            bd[b][sq] = 8'($urandom);
         end
   endtask

   int          exp_n;
   logic [31:0] exp_bi, exp_bs;

   task automatic program_and_start(input logic [31:0] bbase, input logic [31:0] rbase,
                                    input int cnt_wr, input bit side);
      int          sc [$];
      int          best;
      logic [31:0] r;
      exp_n = (cnt_wr > MAXB) ? MAXB : cnt_wr;
      for (int b = 0; b < exp_n; b++) begin
         for (int sq = 0; sq < 64; sq++) begin
            r = $urandom;
            mem[bbase + 32'(b * 256 + sq * 4)] = {r[31:8], bd[b][sq]};
         end
         sc.push_back(ref_score(b));
         exp_q.push_back('{rbase + 32'(4 * b), 32'(sc[b])});
      end
      exp_bi = 32'hFFFF_FFFF;
      exp_bs = 32'h8000_0000;
      if (exp_n > 0) begin
         best = sc[0];
         foreach (sc[i]) if ((side == 0 && sc[i] > best) || (side == 1 && sc[i] < best)) best = sc[i];
         for (int i = exp_n - 1; i >= 0; i--) if (sc[i] == best) exp_bi = 32'(i);
         exp_bs = 32'(best);
      end
      r = $urandom;
      r[0] = side;
      cpu_write(4'd1, bbase);
      cpu_write(4'd2, 32'(cnt_wr));
      cpu_write(4'd3, rbase);
      cpu_write(4'd4, r);
      cpu_write(4'd0, $urandom);
   endtask

   task automatic run_job(input string tag, input logic [31:0] bbase, input logic [31:0] rbase,
                          input int cnt_wr, input bit side, input bit chk_lat);
      logic [31:0] d;
      int          w, rc;
      rc = req_cycles;
      program_and_start(bbase, rbase, cnt_wr, side);
      cpu_read(4'd0, d, w);
      chk({tag, "_best_index"}, d, exp_bi);
      if (exp_n == 0) begin
         checks++;
         if (w > 2) begin
            failures++;
            $display("FAIL %s_done_latency actual=%0d required<=2", tag, w);
         end
         chk({tag, "_no_traffic"}, 32'(req_cycles - rc), 32'd0);
      end else if (chk_lat) begin
         chk({tag, "_latency"}, 32'(last_wr_time - t_start), 32'(194 * exp_n));
      end
      cpu_read(4'd1, d, w);
      chk({tag, "_best_score"}, d, exp_bs);
      repeat (2) @(negedge clk);
      chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, bb, rb;
      logic [31:0] sp [0:7];
      int          w, rc;
      bit          found;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_slave_wait", {31'd0, slave_waitrequest}, 32'd0);
      chk("rst_readdata", slave_readdata, 32'd0);
      chk("rst_master_read", {31'd0, master_read}, 32'd0);
      chk("rst_master_write", {31'd0, master_write}, 32'd0);
      chk("rst_master_addr", master_address, 32'hFFFF_FFFF);
      chk("rst_master_wdata", master_writedata, 32'd0);
      rst_n = 1'b1;

      // Start position minus the black queen.
      clear_boards();
      sp = '{8'd4, 8'd2, 8'd3, 8'd5, 8'd6, 8'd3, 8'd2, 8'd4};
      for (int x = 0; x < 8; x++) begin
         bd[0][x]      = signed'(sp[x][7:0]);
         bd[0][8 + x]  = 8'sd1;
         bd[0][48 + x] = -8'sd1;
         bd[0][56 + x] = (x == 3) ? 8'sd0 : -signed'(sp[x][7:0]);
      end
      run_job("startpos", 32'h0000_1000, 32'h0008_0000, 1, 1'b0, 1'b1);
      chk("startpos_model", exp_bs, 32'd9);

      // Boards scoring 3, 5, 5.
      clear_boards();
      bd[0][0]  = 8'sd2;
      bd[1][63] = 8'sd4;
      bd[2][7]  = 8'sd5;
      for (int i = 8; i < 12; i++) bd[2][i] = -8'sd1;
      run_job("tie_white", 32'h0000_2000, 32'h0008_1000, 3, 1'b0, 1'b1);
      run_job("tie_black", 32'h0000_2000, 32'h0008_2000, 3, 1'b1, 1'b1);
      cpu_read(4'd7, d, w);
      chk("other_addr_zero", d, 32'd0);

      run_job("count0", 32'h0000_3000, 32'h0008_3000, 0, 1'b0, 1'b0);

      // Same random boards with zero-wait and with random stalls/latency.
      for (int k = 0; k < 3; k++) begin
         gen_boards(4);
         bb = 32'h1000_0000 | ($urandom & 32'h00FF_FFFC);
         rb = 32'h4000_0000 | ($urandom & 32'h00FF_FFFC);
         w  = $urandom_range(1, 4);
         rand_mode = 1'b0;
         run_job("rnd_zero", bb, rb, w, 1'($urandom), 1'b1);
         rand_mode = 1'b1;
         run_job("rnd_stall", bb, rb, w, 1'($urandom), 1'b0);
         rand_mode = 1'b0;
      end

      // Oversized count clamps to MAX_BOARDS.
      gen_boards(MAXB);
      run_job("clamp", 32'h2000_0000, 32'h5000_0000, 40, 1'b1, 1'b1);

      // Reset while reading square 20 of board 1, then restart.
      gen_boards(2);
      bb = 32'h0010_0000;
      program_and_start(bb, 32'h0020_0000, 2, 1'b0);
      found = 1'b0;
      for (int n = 0; n < 2000 && !found; n++) begin
         @(negedge clk);
         if (master_read && master_address == bb + 32'd256 + 32'd80) found = 1'b1;
      end
      chk("abort_reached_sq20", {31'd0, found}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_master_read", {31'd0, master_read}, 32'd0);
      chk("abort_master_write", {31'd0, master_write}, 32'd0);
      chk("abort_master_addr", master_address, 32'hFFFF_FFFF);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      rc = req_cycles;
      repeat (10) @(negedge clk);
      chk("abort_quiet", 32'(req_cycles - rc), 32'd0);
      gen_boards(1);
      run_job("restart", 32'h0030_0000, 32'h0040_0000, 1, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
